// File: rtl/axi_rd_arb2_if.sv
// Bus bundle for the two-requester AXI4 read arbiter.
// Requester-side signals (s_*) are packed two-wide, requester 0 in the low slice.
// The memory-side signals (m_*) form one standard AXI4 AR/R channel pair.
interface axi_rd_arb2_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
);
  // requester side
  logic [1:0]          s_arvalid;
  logic [1:0]          s_arready;
  logic [2*ADDR_W-1:0] s_araddr;
  logic [2*LEN_W-1:0]  s_arlen;
  logic [1:0]          s_rvalid;
  logic [1:0]          s_rready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rlast;
  // memory side
  logic [ID_W-1:0]     m_arid;
  logic [ADDR_W-1:0]   m_araddr;
  logic [LEN_W-1:0]    m_arlen;
  logic [2:0]          m_arsize;
  logic [1:0]          m_arburst;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic                m_rvalid;
  logic                m_rready;

  // Arbiter view: takes requests and memory responses, drives grants and AXI requests.
  modport slave (
    input  s_arvalid, s_araddr, s_arlen, s_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    output s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );

  // Environment view: the requesters plus the memory backend.
  modport master (
    output s_arvalid, s_araddr, s_arlen, s_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  s_arready, s_rvalid, s_rdata, s_rresp, s_rlast,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );
endinterface

// File: rtl/axi_rd_arb2.sv
// Two-requester AXI4 read arbiter: round-robin grant per burst, one burst
// outstanding, beats counted against ARLEN, sticky error on protocol violations.
//
// Handshake semantics (all channels): a transfer happens on a rising clk edge
// where valid and ready are both high. The arbiter never makes valid depend on
// ready; s_arready and m_rready are combinational functions of the state and
// of the requester inputs (s_arvalid, s_rready), which is legal AXI since
// ready may depend on valid.
module axi_rd_arb2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  axi_rd_arb2_if.slave     bus,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state,
  output logic             dbg_gnt,
  output logic             dbg_prio,
  output logic [LEN_W:0]   dbg_cnt
);

  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                prio_q, prio_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W:0]      cnt_q, cnt_d;   // one extra bit so a 256-beat burst does not wrap
  logic                err_q, err_d;

  logic                sel;
  logic                rready;
  logic                beat;

  assign bus.m_arsize  = ARSIZE;
  assign bus.m_arburst = 2'b01;

  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;
  assign dbg_gnt   = gnt_q;
  assign dbg_prio  = prio_q;
  assign dbg_cnt   = cnt_q;

  // Next-state logic plus all bus outputs; outputs default to 0 so nothing leaks outside its state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    bus.s_arready = 2'b00;
    bus.s_rvalid  = 2'b00;
    bus.s_rdata   = '0;
    bus.s_rresp   = 2'b00;
    bus.s_rlast   = 1'b0;
    bus.m_arid    = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;

    rready = 1'b0;
    beat   = 1'b0;
    // Favoured requester wins if it asks; otherwise the other one.
    sel    = bus.s_arvalid[prio_q] ? prio_q : ~prio_q;

    case (state_q)
      S_IDLE: begin
        if (|bus.s_arvalid) begin
          bus.s_arready[sel] = 1'b1;
          gnt_d   = sel;
          addr_d  = sel ? bus.s_araddr[2*ADDR_W-1:ADDR_W] : bus.s_araddr[ADDR_W-1:0];
          len_d   = sel ? bus.s_arlen[2*LEN_W-1:LEN_W]    : bus.s_arlen[LEN_W-1:0];
          cnt_d   = '0;
          state_d = S_ADDR;
        end
        // Read data with no burst in flight is dropped and flagged.
        if (bus.m_rvalid) err_d = 1'b1;
      end

      S_ADDR: begin
        bus.m_arvalid = 1'b1;
        bus.m_araddr  = addr_q;
        bus.m_arlen   = len_q;
        bus.m_arid    = {{(ID_W-1){1'b0}}, gnt_q};
        if (bus.m_arready) state_d = S_DATA;
        if (bus.m_rvalid) err_d = 1'b1;
      end

      S_DATA: begin
        rready                = bus.s_rready[gnt_q];
        bus.m_rready          = rready;
        bus.s_rvalid[gnt_q]   = bus.m_rvalid;
        bus.s_rdata           = bus.m_rdata;
        bus.s_rresp           = bus.m_rresp;
        bus.s_rlast           = bus.m_rlast;
        beat                  = bus.m_rvalid & rready;
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (bus.m_rlast) begin
            // Early last: burst ends before len_q+1 beats.
            if (cnt_q != {1'b0, len_q}) err_d = 1'b1;
            state_d = S_IDLE;
            prio_d  = ~gnt_q;
          end else if (cnt_q == {1'b0, len_q}) begin
            // Missing last: keep draining until the backend finally asserts rlast.
            err_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Self-checking bench for axi_rd_arb2: scripted requesters and memory backend,
// read beats checked through an expected queue of {owner, data}.
module tb_axi_rd_arb2;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_rd_arb2_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  logic             busy;
  logic             err;
  logic [1:0]       dbg_state;
  logic             dbg_gnt;
  logic             dbg_prio;
  logic [LEN_W:0]   dbg_cnt;

  axi_rd_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err       (err),
    .dbg_state (dbg_state),
    .dbg_gnt   (dbg_gnt),
    .dbg_prio  (dbg_prio),
    .dbg_cnt   (dbg_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  logic [DATA_W:0] exp_q[$];   // {owner, data}
  logic [DATA_W:0] sb_exp;
  logic [DATA_W:0] sb_got;
  int              beats_seen = 0;
  int              ar_hs = 0;

  // Pop and compare on every requester-side beat handshake.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.m_arvalid && bus.m_arready) ar_hs++;
      for (int i = 0; i < 2; i++) begin
        if (bus.s_rvalid[i] && bus.s_rready[i]) begin
          n_tests++;
          beats_seen++;
          sb_got = {i[0], bus.s_rdata};
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_beat: got owner %0d data %h, expected no beat", i, bus.s_rdata);
          end else begin
            sb_exp = exp_q.pop_front();
            if (sb_got !== sb_exp)  begin
              n_fail++;
              $display("FAIL sb_beat: got owner %0d data %h, expected owner %0d data %h",
                       sb_got[DATA_W], sb_got[DATA_W-1:0], sb_exp[DATA_W], sb_exp[DATA_W-1:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s_arvalid = 2'b00;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_rready  = 2'b00;
    bus.m_arready = 1'b0;
    bus.m_rdata   = '0;
    bus.m_rresp   = 2'b00;
    bus.m_rlast   = 1'b0;
    bus.m_rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic request(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    bus.s_arvalid[i] = 1'b1;
    if (i == 0) begin
      bus.s_araddr[ADDR_W-1:0] = a;
      bus.s_arlen[LEN_W-1:0]   = l;
    end else begin
      bus.s_araddr[2*ADDR_W-1:ADDR_W] = a;
      bus.s_arlen[2*LEN_W-1:LEN_W]    = l;
    end
  endtask

  // Present one R beat; it is expected at the owner only if the owner is ready.
  task automatic beat(input int owner, input logic [DATA_W-1:0] d, input logic last);
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = d;
    bus.m_rlast  = last;
    bus.m_rresp  = 2'($urandom_range(0, 3));
    if (bus.s_rready[owner]) exp_q.push_back({owner[0], d});
  endtask

  task automatic idle_r();
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.m_rdata  = '0;
  endtask

  // Accept a request and complete the AR handshake immediately.
  task automatic open_burst(input int i, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    request(i, a, l);
    bus.m_arready = 1'b1;
    step();
    bus.s_arvalid = 2'b00;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_tests++; if ({dbg_gnt, dbg_prio} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_prio: got %b want 00", {dbg_gnt, dbg_prio}); end
    n_tests++; if ({bus.m_arvalid, bus.m_rready, bus.s_arready, bus.s_rvalid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 000000", {bus.m_arvalid, bus.m_rready, bus.s_arready, bus.s_rvalid});
    end
    n_tests++; if (bus.m_arsize !== 3'd2) begin n_fail++; $display("FAIL reset_arsize: got %0d want 2", bus.m_arsize); end
    n_tests++; if (bus.m_arburst !== 2'b01) begin n_fail++; $display("FAIL reset_arburst: got %b want 01", bus.m_arburst); end
    n_tests++; if ({bus.m_arid, bus.m_araddr, bus.m_arlen} !== '0) begin n_fail++; $display("FAIL reset_ar_fields: got nonzero"); end
  endtask

  task automatic test_single();
    do_reset();
    bus.s_rready = 2'b11;
    bus.m_arready = 1'b1;
    request(0, 32'h100, 8'd3);
    @(negedge clk);
    n_tests++; if (bus.s_arready !== 2'b01) begin n_fail++; $display("FAIL single_arready: got %b want 01", bus.s_arready); end
    step();
    bus.s_arvalid = 2'b00;
    @(negedge clk);
    n_tests++; if ({bus.m_arvalid, bus.m_araddr, bus.m_arid, bus.m_arlen} !== {1'b1, 32'h100, 4'd0, 8'd3}) begin
      n_fail++; $display("FAIL single_ar: got v=%b a=%h id=%0d len=%0d want v=1 a=100 id=0 len=3",
                         bus.m_arvalid, bus.m_araddr, bus.m_arid, bus.m_arlen);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      beat(0, 32'hA0 + 32'(k), k == 3);
      @(negedge clk);
      n_tests++; if (bus.s_rvalid !== 2'b01) begin n_fail++; $display("FAIL single_rvalid beat %0d: got %b want 01", k, bus.s_rvalid); end
      n_tests++; if ({bus.m_arvalid, busy} !== 2'b01) begin n_fail++; $display("FAIL single_busy beat %0d: got arvalid,busy=%b want 01", k, {bus.m_arvalid, busy}); end
      step();
    end
    idle_r();
    @(negedge clk);
    n_tests++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL single_end: got busy,err=%b want 00", {busy, err}); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_sb_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_contention();
    int g;
    do_reset();
    bus.s_rready  = 2'b11;
    bus.m_arready = 1'b1;
    request(0, 32'h1000, 8'd0);
    request(1, 32'h2000, 8'd0);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      @(negedge clk);
      n_tests++; if (bus.s_arready !== 2'(1 << g)) begin n_fail++; $display("FAIL contention_grant %0d: got %b want %b", k, bus.s_arready, 2'(1 << g)); end
      step();
      if (k == 3) bus.s_arvalid = 2'b00;
      @(negedge clk);
      n_tests++; if ({bus.m_arid, bus.m_araddr} !== {4'(g), (g == 1) ? 32'h2000 : 32'h1000}) begin
        n_fail++; $display("FAIL contention_arid %0d: got id=%0d a=%h want id=%0d", k, bus.m_arid, bus.m_araddr, g);
      end
      step();
      beat(g, 32'hC0 + 32'(k), 1'b1);
      @(negedge clk);
      n_tests++; if (bus.s_rvalid !== 2'(1 << g)) begin n_fail++; $display("FAIL contention_route %0d: got %b want %b", k, bus.s_rvalid, 2'(1 << g)); end
      step();
      idle_r();
    end
    @(negedge clk);
    n_tests++; if ({busy, bus.s_arready} !== 3'b000) begin n_fail++; $display("FAIL contention_end: got busy,arready=%b want 000", {busy, bus.s_arready}); end
  endtask

  task automatic test_backpressure();
    int hs0;
    do_reset();
    bus.s_rready = 2'b11;
    request(1, 32'h2000_0040, 8'd3);
    @(negedge clk);
    n_tests++; if (bus.s_arready !== 2'b10) begin n_fail++; $display("FAIL bp_arready: got %b want 10", bus.s_arready); end
    step();
    bus.s_arvalid = 2'b00;
    hs0 = ar_hs;
    for (int c = 0; c < 6; c++) begin
      bus.m_arready = (c == 5);
      @(negedge clk);
      n_tests++; if ({bus.m_arvalid, bus.m_araddr, bus.m_arlen, bus.m_arid} !== {1'b1, 32'h2000_0040, 8'd3, 4'd1}) begin
        n_fail++; $display("FAIL bp_ar_stable cycle %0d: got v=%b a=%h len=%0d id=%0d", c, bus.m_arvalid, bus.m_araddr, bus.m_arlen, bus.m_arid);
      end
      step();
    end
    bus.m_arready = 1'b0;
    beat(1, 32'hB0, 1'b0);
    @(negedge clk);
    n_tests++; if (ar_hs - hs0 != 1) begin n_fail++; $display("FAIL bp_ar_handshakes: got %0d want 1", ar_hs - hs0); end
    step();
    bus.s_rready[1] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      beat(1, 32'hB1, 1'b0);
      @(negedge clk);
      n_tests++; if ({bus.m_rready, bus.s_rvalid} !== 3'b010) begin
        n_fail++; $display("FAIL bp_stall cycle %0d: got rready=%b rvalid=%b want 0 10", s, bus.m_rready, bus.s_rvalid);
      end
      step();
    end
    bus.s_rready[1] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      beat(1, 32'hB0 + 32'(k), k == 3);
      step();
    end
    idle_r();
    @(negedge clk);
    n_tests++; if ({busy, err, dbg_prio} !== 3'b000) begin n_fail++; $display("FAIL bp_end: got busy,err,prio=%b want 000", {busy, err, dbg_prio}); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_sb_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_len_errors();
    // Early last on the second beat of a 4-beat burst.
    do_reset();
    bus.s_rready = 2'b11;
    open_burst(0, 32'h300, 8'd3);
    beat(0, 32'hD0, 1'b0);
    step();
    beat(0, 32'hD1, 1'b1);
    @(negedge clk);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL early_last_pre: got err=%b want 0", err); end
    step();
    idle_r();
    @(negedge clk);
    n_tests++; if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL early_last: got err,busy=%b want 10", {err, busy}); end

    // Missing last: 2-beat burst, rlast only on a third beat.
    do_reset();
    bus.s_rready = 2'b11;
    open_burst(0, 32'h400, 8'd1);
    beat(0, 32'hE0, 1'b0);
    step();
    beat(0, 32'hE1, 1'b0);
    step();
    idle_r();
    @(negedge clk);
    n_tests++; if ({err, dbg_state} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL missing_last: got err=%b state=%0d want 1 2", err, dbg_state); end
    beat(0, 32'hE2, 1'b1);
    step();
    idle_r();
    @(negedge clk);
    n_tests++; if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL missing_last_end: got err,busy=%b want 10", {err, busy}); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL len_sb_left: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_max_burst();
    int b0;
    do_reset();
    bus.s_rready = 2'b11;
    open_burst(0, 32'h8000, 8'd255);
    b0 = beats_seen;
    for (int k = 0; k < 256; k++) begin
      beat(0, 32'(k * 3 + 1), k == 255);
      if (k == 255) begin
        @(negedge clk);
        n_tests++; if (dbg_cnt !== 9'd255) begin n_fail++; $display("FAIL max_cnt: got %0d want 255", dbg_cnt); end
      end
      step();
    end
    idle_r();
    @(negedge clk);
    n_tests++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL max_end: got busy,err=%b want 00", {busy, err}); end
    n_tests++; if (beats_seen - b0 != 256) begin n_fail++; $display("FAIL max_beats: got %0d want 256", beats_seen - b0); end
    n_tests++; if (dbg_cnt !== 9'd256) begin n_fail++; $display("FAIL max_cnt_nowrap: got %0d want 256", dbg_cnt); end

    // Second long burst abandoned by a one-cycle reset.
    open_burst(1, 32'h9000, 8'd255);
    for (int k = 0; k < 10; k++) begin
      beat(1, 32'h900 + 32'(k), 1'b0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_r();
    exp_q.delete();
    @(negedge clk);
    n_tests++; if ({dbg_state, busy, bus.m_arvalid, bus.m_rready, dbg_prio} !== 6'b0) begin
      n_fail++; $display("FAIL midreset: got state=%0d busy=%b arvalid=%b rready=%b prio=%b want all 0",
                         dbg_state, busy, bus.m_arvalid, bus.m_rready, dbg_prio);
    end
  endtask

  task automatic test_stray();
    do_reset();
    bus.s_rready = 2'b11;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'hFF;
    @(negedge clk);
    n_tests++; if ({bus.m_rready, bus.s_rvalid, err} !== 4'b0000) begin
      n_fail++; $display("FAIL stray_block: got rready=%b rvalid=%b err=%b want 0 00 0", bus.m_rready, bus.s_rvalid, err);
    end
    step();
    idle_r();
    @(negedge clk);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL stray_err: got %b want 1", err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_len_errors();
    test_max_burst();
    test_stray();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_sb_left: got %0d pending want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
